// File: rtl/inv_add_round_key_mix.sv
// Decrypt-side AddRoundKey followed by InvMixColumns (bypassed on the last round),
// as a two-stage valid/ready pipeline that collapses bubbles.
module inv_add_round_key_mix #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  invARK_valid_in,
  output logic                  invARK_ready_out,
  input  logic                  invARK_last_in,
  input  logic [DATA_WIDTH-1:0] invARK_data_in,
  input  logic [KEY_WIDTH-1:0]  invARK_key_in,
  output logic [DATA_WIDTH-1:0] invARK_data_out,
  output logic                  invARK_valid_out,
  input  logic                  invARK_ready_in
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  // One column: each coefficient is assembled from the x2/x4/x8 xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned r = 0; r < 4; r++) begin
      a[r]  = col[31 - 8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] inv_mix(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_last_q,  s1_last_d;
  logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;
  logic                  s1_adv, s2_adv;

  always_comb begin
    s2_adv = !s2_valid_q || invARK_ready_in;
    s1_adv = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_last_q ? s1_data_q : inv_mix(s1_data_q);
    end
    if (s1_adv) begin
      s1_valid_d = invARK_valid_in;
      s1_last_d  = invARK_last_in;
      s1_data_d  = invARK_data_in ^ invARK_key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign invARK_ready_out = s1_adv;
  assign invARK_valid_out = s2_valid_q;
  assign invARK_data_out  = s2_valid_q ? s2_data_q : '0;

endmodule

// File: doc/inv_add_round_key_mix.md
Name: inv_add_round_key_mix

Overview:
Decrypt-direction counterpart of the encrypt-side add round key stage. Applies AddRoundKey and then InvMixColumns, the order the AES inverse cipher uses. A last-round flag bypasses InvMixColumns for the final decrypt round. Two-stage registered pipeline with valid/ready handshake. Sits after InvShiftRows/InvSubBytes in the iterative decrypt datapath and feeds the next round or the plaintext output.

Parameters:
DATA_WIDTH, 128, state width in bits; only 128 is legal.
KEY_WIDTH, 128, round key width in bits; always 128, also for AES-256 round keys.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
invARK_valid_in  input  1  input state and key valid this cycle
invARK_ready_out  output  1  block can accept input this cycle
invARK_last_in  input  1  final decrypt round: skip InvMixColumns
invARK_data_in  input  128  state after InvSubBytes
invARK_key_in  input  128  round key for this round
invARK_data_out  output  128  processed state
invARK_valid_out  output  1  data_out valid
invARK_ready_in  input  1  downstream accepts data_out

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Byte order: byte 0 = bits [127:120]. Column c = bytes 4c..4c+3, column-major per FIPS-197. Byte 4c is row 0.
- Stage 1 (S1) registers:
  - s1_data = data_in ^ key_in
  - s1_last = last_in
  - s1_valid
- Stage 2 (S2) registers:
  - s2_valid
  - s2_data = s1_last ? s1_data : InvMixColumns(s1_data)
- InvMixColumns, per column (a0..a3) in GF(2^8), poly 0x11B:
  - b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - b2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - b3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
  - Built from xtime chains. Purely combinational between S1 and S2; no lookup tables.
- Handshake:
  - s2_adv = !s2_valid || ready_in
  - s1_adv = !s1_valid || s2_adv
  - ready_out = s1_adv (combinational)
  - Input transfer when valid_in && ready_out.
  - Output transfer when valid_out && ready_in.
- Latency and throughput:
  - 2 cycles input-to-output when not stalled.
  - One state per cycle sustained while ready_in stays high.
- Bubbles: bubble-collapsing. An empty S2 accepts from S1 even when ready_in is low.
- Stall:
  - With S2 full and ready_in low, S2 holds data and valid stable.
  - If S1 is also full, S1 holds and ready_out goes low.
  - No data lost or duplicated.
- Simultaneous events: when S2 drains (ready_in high) in the same cycle S1 loads new input, both transfers occur. Pipeline remains full.
- Outputs:
  - valid_out = s2_valid.
  - data_out = s2_data when s2_valid, else all zeros. Invalid data is never exposed.
- Reset:
  - s1_valid, s2_valid, s1_last = 0; s1_data, s2_data = 0.
  - After reset: valid_out = 0, data_out = 0, ready_out = 1.
  - Reset mid-operation discards in-flight states. No output on the cycle after reset.
- last_in travels with its state; it is sampled only on the input transfer.
- valid_in low with ready_out high: S1 loads a bubble (s1_valid = 0); data in S1 is don't-care.

Test Plan:
- Reset then idle -> valid_out = 0, data_out = 0, ready_out = 1 every cycle.
- Last-round bypass: data_in = 54776f204f6e65204e696e652054776f, key = 5468617473206d79204b756e67204675, last = 1 -> two cycles later data_out = 001f0e543c4e08596e221b0b4774311a, valid_out = 1.
- InvMixColumns: key = 0, last = 0, data_in = 8e4da1bc 9fdc589d 01010101 c6c6c6c6 -> data_out = db135345 f20a225c 01010101 c6c6c6c6.
- Back-to-back stream:
  - Input: 8 states on consecutive cycles, ready_in = 1, alternating last flag.
  - Required: outputs in order, 2-cycle latency, no gaps, each value matching the software model.
- Backpressure:
  - Input: ready_in low for 5 cycles while 3 states are offered.
  - Required: ready_out drops after 2 accepted, data_out holds stable.
  - On release, all 3 states emerge in order with no duplicates.
- Mid-stream reset: rst asserted with both stages full -> next cycle valid_out = 0, data_out = 0. The next accepted state emerges correctly 2 cycles after its transfer.
